// File: rtl/avalon_mon_pkg.sv
// rtl/avalon_mon_pkg.sv - shared types and helpers for the Avalon-MM protocol monitor
package avalon_mon_pkg;

    typedef enum logic [2:0] {
        MODE_BASIC      = 3'd0,
        MODE_FIXED_WAIT = 3'd1,
        MODE_PIPE_FIXED = 3'd2,
        MODE_PIPE_VAR   = 3'd3,
        MODE_BURST      = 3'd4
    } avmon_mode_e;

    typedef enum logic [3:0] {
        ERR_NONE         = 4'd0,
        ERR_RW_BOTH      = 4'd1,
        ERR_UNSTABLE     = 4'd2,
        ERR_SPURIOUS_RDV = 4'd3,
        ERR_OVERFLOW     = 4'd4,
        ERR_LATENCY      = 4'd5,
        ERR_BURST_ZERO   = 4'd6,
        ERR_BURST_BEGIN  = 4'd7,
        ERR_TIMEOUT      = 4'd8
    } avmon_err_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WR_BURST = 2'd2
    } avmon_state_e;

    localparam int NUM_ERR = 9;

    // Lowest-numbered set bit wins when several rules break in one cycle.
    function automatic avmon_err_e first_err(input logic [NUM_ERR-1:0] vec);
        first_err = ERR_NONE;
        for (int i = NUM_ERR - 1; i >= 1; i--) begin
            if (vec[i]) first_err = avmon_err_e'(i);
        end
    endfunction

endpackage

// File: rtl/avalon_mon_rd_tracker.sv
// rtl/avalon_mon_rd_tracker.sv - read-latency shift register, outstanding-beat counter and timeout
module avalon_mon_rd_tracker
    import avalon_mon_pkg::*;
#(
    parameter int AVALONMODE = 0,
    parameter int FIXEDDELAY = 2,
    parameter int MAXPEND    = 8,
    parameter int TIMEOUT    = 256,
    parameter int OUTW       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            acc_read,
    input  logic [7:0]      acc_beats,
    input  logic            rdv,
    output logic [OUTW-1:0] outstanding,
    output logic            beat_done,
    output logic            err_spurious,
    output logic            err_overflow,
    output logic            err_latency,
    output logic            err_timeout
);
    localparam bit IS_FIX = (AVALONMODE == int'(MODE_PIPE_FIXED));
    localparam bit IS_VAR = (AVALONMODE == int'(MODE_PIPE_VAR)) || (AVALONMODE == int'(MODE_BURST));
    localparam int SRW    = (FIXEDDELAY < 1) ? 1 : FIXEDDELAY;
    localparam int TOW    = $clog2(TIMEOUT + 1);
    localparam int CW     = OUTW + 9;

    logic [SRW-1:0]  sr_q, sr_d;
    logic [OUTW-1:0] out_q, out_d;
    logic [TOW-1:0]  to_q, to_d;
    logic            tap, dec;
    logic [CW-1:0]   sum;

    // Mode 2 compares rdv against the delayed accept; modes 3/4 net accepts against returns.
    always_comb begin
        sr_d         = '0;
        out_d        = '0;
        to_d         = '0;
        tap          = sr_q[SRW-1];
        dec          = 1'b0;
        sum          = '0;
        beat_done    = 1'b0;
        err_spurious = 1'b0;
        err_overflow = 1'b0;
        err_latency  = 1'b0;
        err_timeout  = 1'b0;
        if (IS_FIX || IS_VAR) begin
            if (IS_FIX) begin
                sr_d        = (sr_q << 1) | SRW'(acc_read);
                dec         = tap && (out_q != '0);
                err_latency = (rdv != tap);
                beat_done   = rdv;
            end else begin
                dec          = rdv && (out_q != '0);
                err_spurious = rdv && (out_q == '0);
                beat_done    = dec;
            end
            sum = CW'(out_q) + (acc_read ? CW'(acc_beats) : CW'(0)) - CW'(dec);
            if (sum > CW'(MAXPEND)) begin
                out_d        = OUTW'(MAXPEND);
                err_overflow = IS_VAR;
            end else begin
                out_d = sum[OUTW-1:0];
            end
            // Any return or an empty queue restarts the wait; firing rearms the counter.
            if ((out_q == '0) || rdv) begin
                to_d = '0;
            end else if (to_q == TOW'(TIMEOUT - 1)) begin
                to_d        = '0;
                err_timeout = 1'b1;
            end else begin
                to_d = to_q + TOW'(1);
            end
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            out_q <= '0;
            to_q  <= '0;
        end else begin
            sr_q  <= sr_d;
            out_q <= out_d;
            to_q  <= to_d;
        end
    end

    assign outstanding = out_q;

endmodule

// File: rtl/avalon_protocol_monitor.sv
// rtl/avalon_protocol_monitor.sv - passive Avalon-MM slave-side protocol checker (optional AVMON_ERR_LOG_EN first-error log)
module avalon_protocol_monitor
    import avalon_mon_pkg::*;
#(
    parameter int AVALONMODE  = 0,
    parameter int NBDATABYTES = 2,
    parameter int NBADDRBITS  = 8,
    parameter int WRITEDELAY  = 2,
    parameter int READDELAY   = 1,
    parameter int FIXEDDELAY  = 2,
    parameter int MAXPEND     = 8,
    parameter int TIMEOUT     = 256,
    localparam int DATAW      = 8 * NBDATABYTES,
    localparam int OUTW       = $clog2(MAXPEND + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NBADDRBITS-1:0]  address,
    input  logic [NBDATABYTES-1:0] byteenable,
    input  logic [DATAW-1:0]       readdata,
    input  logic [DATAW-1:0]       writedata,
    input  logic                   read,
    input  logic                   write,
    input  logic                   waitrequest,
    input  logic                   readdatavalid,
    input  logic [7:0]             burstcount,
    input  logic                   beginbursttransfer,
    output logic                   err_valid,
    output logic [3:0]             err_code,
    output logic [NUM_ERR-1:0]     err_sticky,
    output logic [OUTW-1:0]        outstanding,
    output logic [15:0]            rd_beats
`ifdef AVMON_ERR_LOG_EN
    ,
    output logic [3:0]             err_first_code,
    output logic [NBADDRBITS-1:0]  err_first_addr,
    output logic [31:0]            err_first_cycle
`endif
);
    localparam bit IS_M1   = (AVALONMODE == int'(MODE_FIXED_WAIT));
    localparam bit IS_M4   = (AVALONMODE == int'(MODE_BURST));
    localparam bit IS_PIPE = (AVALONMODE >= int'(MODE_PIPE_FIXED));
    localparam logic [7:0] RD_LEN = 8'(READDELAY + 1);
    localparam logic [7:0] WR_LEN = 8'(WRITEDELAY + 1);

    logic cmd;
    logic unused_rdata;
    assign cmd          = read | write;
    assign unused_rdata = ^readdata;

    avmon_state_e          state_q, state_d;
    logic [7:0]            hold_cnt_q, hold_cnt_d, beat_cnt_q, beat_cnt_d, bc_q, bc_d;
    logic                  hold_rd_q, hold_rd_d, acc_prev_q, acc_prev_d;
    logic [NBADDRBITS-1:0] baddr_q, baddr_d;
    logic                  m1_done, m1_done_rd, m1_early, m1_late, burst_unstable;

    logic                   stall_q, stall_d, prev_read_q, prev_read_d, prev_write_q, prev_write_d;
    logic [NBADDRBITS-1:0]  prev_addr_q, prev_addr_d;
    logic [NBDATABYTES-1:0] prev_be_q, prev_be_d;
    logic [DATAW-1:0]       prev_wd_q, prev_wd_d;
    logic [7:0]             prev_bc_q, prev_bc_d;
    logic                   unstable, fields_changed, exp_bbt, acc_read;

    logic [NUM_ERR-1:0] err_vec, err_sticky_q, err_sticky_d;
    logic               err_valid_q, err_valid_d;
    avmon_err_e         err_code_q, err_code_d;
    logic [15:0]        rd_beats_q, rd_beats_d;
    logic               trk_beat_done, trk_spurious, trk_overflow, trk_latency, trk_timeout;

    // Mode 1 hold-window FSM and mode 4 write-burst FSM share one state register.
    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        hold_rd_d      = hold_rd_q;
        beat_cnt_d     = beat_cnt_q;
        bc_d           = bc_q;
        baddr_d        = baddr_q;
        acc_prev_d     = 1'b0;
        m1_done        = 1'b0;
        m1_done_rd     = 1'b0;
        m1_early       = 1'b0;
        m1_late        = 1'b0;
        burst_unstable = 1'b0;
        if (IS_M1) begin
            case (state_q)
                IDLE: begin
                    if (cmd && acc_prev_q) begin
                        m1_late = 1'b1;
                    end else if (cmd && ((read ? RD_LEN : WR_LEN) == 8'd1)) begin
                        m1_done    = 1'b1;
                        m1_done_rd = read;
                    end else if (cmd) begin
                        state_d    = HOLD;
                        hold_cnt_d = 8'd1;
                        hold_rd_d  = read;
                    end
                end
                HOLD: begin
                    if (hold_rd_q ? read : write) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                        if ((hold_cnt_q + 8'd1) == (hold_rd_q ? RD_LEN : WR_LEN)) begin
                            m1_done    = 1'b1;
                            m1_done_rd = hold_rd_q;
                            state_d    = IDLE;
                        end
                    end else begin
                        m1_early = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            acc_prev_d = m1_done | m1_late;
        end else if (IS_M4) begin
            case (state_q)
                IDLE: begin
                    if (write && !waitrequest && (burstcount > 8'd1)) begin
                        state_d    = WR_BURST;
                        beat_cnt_d = 8'd1;
                        bc_d       = burstcount;
                        baddr_d    = address;
                    end
                end
                WR_BURST: begin
                    burst_unstable = read || (write && ((burstcount != bc_q) || (address != baddr_q)));
                    if (write && !waitrequest) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        if ((beat_cnt_q + 8'd1) == bc_q) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Per-cycle rule checks and the registered error/beat outputs they feed.
    always_comb begin
        acc_read     = IS_M1 ? m1_done_rd : (read && !waitrequest);
        stall_d      = IS_M1 ? (state_d == HOLD) : (cmd && waitrequest);
        prev_read_d  = read;
        prev_write_d = write;
        prev_addr_d  = address;
        prev_be_d    = byteenable;
        prev_wd_d    = writedata;
        prev_bc_d    = burstcount;

        fields_changed = (address != prev_addr_q) || (byteenable != prev_be_q) ||
                         (prev_write_q && (writedata != prev_wd_q)) ||
                         (IS_M4 && (burstcount != prev_bc_q));
        unstable = 1'b0;
        if (stall_q) begin
            unstable = IS_M1 ? (cmd && fields_changed)
                             : ((read != prev_read_q) || (write != prev_write_q) || fields_changed);
        end
        exp_bbt = cmd && !stall_q && (state_q == IDLE);

        err_vec                           = '0;
        err_vec[int'(ERR_RW_BOTH)]        = read && write;
        err_vec[int'(ERR_UNSTABLE)]       = unstable || burst_unstable;
        err_vec[int'(ERR_SPURIOUS_RDV)]   = trk_spurious;
        err_vec[int'(ERR_OVERFLOW)]       = trk_overflow;
        err_vec[int'(ERR_LATENCY)]        = m1_early || m1_late || trk_latency;
        err_vec[int'(ERR_BURST_ZERO)]     = IS_M4 && cmd && (burstcount == 8'd0);
        err_vec[int'(ERR_BURST_BEGIN)]    = IS_M4 && (beginbursttransfer != exp_bbt);
        err_vec[int'(ERR_TIMEOUT)]        = trk_timeout;

        err_valid_d  = |err_vec;
        err_code_d   = first_err(err_vec);
        err_sticky_d = err_sticky_q | err_vec;
        rd_beats_d   = rd_beats_q;
        if ((IS_PIPE ? trk_beat_done : acc_read) && (rd_beats_q != 16'hFFFF)) begin
            rd_beats_d = rd_beats_q + 16'd1;
        end
    end

    // Monitor state registers; reset silently discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            hold_rd_q    <= 1'b0;
            acc_prev_q   <= 1'b0;
            beat_cnt_q   <= '0;
            bc_q         <= '0;
            baddr_q      <= '0;
            stall_q      <= 1'b0;
            prev_read_q  <= 1'b0;
            prev_write_q <= 1'b0;
            prev_addr_q  <= '0;
            prev_be_q    <= '0;
            prev_wd_q    <= '0;
            prev_bc_q    <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_sticky_q <= '0;
            rd_beats_q   <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_rd_q    <= hold_rd_d;
            acc_prev_q   <= acc_prev_d;
            beat_cnt_q   <= beat_cnt_d;
            bc_q         <= bc_d;
            baddr_q      <= baddr_d;
            stall_q      <= stall_d;
            prev_read_q  <= prev_read_d;
            prev_write_q <= prev_write_d;
            prev_addr_q  <= prev_addr_d;
            prev_be_q    <= prev_be_d;
            prev_wd_q    <= prev_wd_d;
            prev_bc_q    <= prev_bc_d;
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
            err_sticky_q <= err_sticky_d;
            rd_beats_q   <= rd_beats_d;
        end
    end

    avalon_mon_rd_tracker #(
        .AVALONMODE (AVALONMODE),
        .FIXEDDELAY (FIXEDDELAY),
        .MAXPEND    (MAXPEND),
        .TIMEOUT    (TIMEOUT),
        .OUTW       (OUTW)
    ) u_rd_tracker (
        .clk          (clk),
        .rst          (rst),
        .acc_read     (acc_read),
        .acc_beats    (IS_M4 ? burstcount : 8'd1),
        .rdv          (readdatavalid),
        .outstanding  (outstanding),
        .beat_done    (trk_beat_done),
        .err_spurious (trk_spurious),
        .err_overflow (trk_overflow),
        .err_latency  (trk_latency),
        .err_timeout  (trk_timeout)
    );

    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_sticky = err_sticky_q;
    assign rd_beats   = rd_beats_q;

`ifdef AVMON_ERR_LOG_EN
    logic [31:0]           cyc_q, cyc_d, first_cyc_q, first_cyc_d;
    logic                  first_seen_q, first_seen_d;
    logic [3:0]            first_code_q, first_code_d;
    logic [NBADDRBITS-1:0] first_addr_q, first_addr_d;

    // Capture the first violation of this reset epoch with its address and cycle stamp.
    always_comb begin
        cyc_d        = cyc_q + 32'd1;
        first_seen_d = first_seen_q;
        first_code_d = first_code_q;
        first_addr_d = first_addr_q;
        first_cyc_d  = first_cyc_q;
        if (!first_seen_q && (|err_vec)) begin
            first_seen_d = 1'b1;
            first_code_d = first_err(err_vec);
            first_addr_d = address;
            first_cyc_d  = cyc_q;
        end
    end

    // First-error log registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q        <= '0;
            first_seen_q <= 1'b0;
            first_code_q <= '0;
            first_addr_q <= '0;
            first_cyc_q  <= '0;
        end else begin
            cyc_q        <= cyc_d;
            first_seen_q <= first_seen_d;
            first_code_q <= first_code_d;
            first_addr_q <= first_addr_d;
            first_cyc_q  <= first_cyc_d;
        end
    end

    assign err_first_code  = first_code_q;
    assign err_first_addr  = first_addr_q;
    assign err_first_cycle = first_cyc_q;
`endif

endmodule

// File: tb/tb_avalon_protocol_monitor.sv
// tb/tb_avalon_protocol_monitor.sv - scoreboard bench driving one monitor per mode on a shared bus
module tb_avalon_protocol_monitor;
    localparam int ND = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  address;
    logic [1:0]  byteenable;
    logic [15:0] readdata, writedata;
    logic        read, write, waitrequest, readdatavalid, beginbursttransfer;
    logic [7:0]  burstcount;

    logic        ev [ND];
    logic [3:0]  ec [ND];
    logic [8:0]  es [ND];
    logic [3:0]  os [ND];
    logic [15:0] rb [ND];

    typedef struct {
        int         dut;
        logic [3:0] code;
    } exp_t;
    exp_t sb[$];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        avalon_protocol_monitor #(
            .AVALONMODE  (g),
            .NBDATABYTES (2),
            .NBADDRBITS  (8),
            .WRITEDELAY  (2),
            .READDELAY   (1),
            .FIXEDDELAY  (2),
            .MAXPEND     (8),
            .TIMEOUT     (256)
        ) u_dut (
            .clk                (clk),
            .rst                (rst),
            .address            (address),
            .byteenable         (byteenable),
            .readdata           (readdata),
            .writedata          (writedata),
            .read               (read),
            .write              (write),
            .waitrequest        (waitrequest),
            .readdatavalid      (readdatavalid),
            .burstcount         (burstcount),
            .beginbursttransfer (beginbursttransfer),
            .err_valid          (ev[g]),
            .err_code           (ec[g]),
            .err_sticky         (es[g]),
            .outstanding        (os[g]),
            .rd_beats           (rb[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_bus();
        read               = 1'b0;
        write              = 1'b0;
        waitrequest        = 1'b0;
        readdatavalid      = 1'b0;
        beginbursttransfer = 1'b0;
        burstcount         = 8'd1;
        address            = 8'h00;
        byteenable         = 2'b11;
        writedata          = 16'h0000;
        readdata           = 16'h0000;
    endtask

    // Push the expectation for the cycle just driven, clock it, then pop and compare.
    task automatic cyc(input int d, input logic [3:0] code);
        exp_t e;
        sb.push_back('{dut: d, code: code});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("m%0d_err_valid", e.dut), 32'(ev[e.dut]), 32'(e.code != 4'd0));
            check($sformatf("m%0d_err_code", e.dut), 32'(ec[e.dut]), 32'(e.code));
        end
    endtask

    task automatic do_reset(input bit check_out);
        rst = 1'b1;
        idle_bus();
        #2;
        if (check_out) begin
            for (int d = 0; d < ND; d++) begin
                check($sformatf("rst_m%0d_err_valid", d), 32'(ev[d]), 32'd0);
                check($sformatf("rst_m%0d_err_code", d), 32'(ec[d]), 32'd0);
                check($sformatf("rst_m%0d_err_sticky", d), 32'(es[d]), 32'd0);
                check($sformatf("rst_m%0d_outstanding", d), 32'(os[d]), 32'd0);
                check($sformatf("rst_m%0d_rd_beats", d), 32'(rb[d]), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_bus();
        do_reset(1'b1);

        // Mode 0: read&write together, address change under stall, command dropped under stall.
        for (int i = 0; i < 9; i++) cyc(0, 4'd0);
        read = 1'b1; write = 1'b1;                          cyc(0, 4'd1);
        idle_bus();                                         cyc(0, 4'd0);
        check("m0_sticky_rw", 32'(es[0]), 32'h002);
        read = 1'b1; address = 8'h10; waitrequest = 1'b1;   cyc(0, 4'd0);
        address = 8'h11;                                    cyc(0, 4'd2);
        waitrequest = 1'b0;                                 cyc(0, 4'd0);
        idle_bus();                                         cyc(0, 4'd0);
        read = 1'b1; waitrequest = 1'b1;                    cyc(0, 4'd0);
        read = 1'b0;                                        cyc(0, 4'd2);
        idle_bus();                                         cyc(0, 4'd0);
        check("m0_sticky", 32'(es[0]), 32'h006);
        check("m0_rd_beats", 32'(rb[0]), 32'd2);

        // Mode 1: exact hold windows, early drop, late deassert.
        do_reset(1'b0);
        read = 1'b1;                                        cyc(1, 4'd0);
                                                            cyc(1, 4'd0);
        idle_bus();                                         cyc(1, 4'd0);
        write = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1, 4'd0);
        idle_bus();                                         cyc(1, 4'd0);
        write = 1'b1;                                       cyc(1, 4'd0);
                                                            cyc(1, 4'd0);
        idle_bus();                                         cyc(1, 4'd5);
                                                            cyc(1, 4'd0);
        read = 1'b1;                                        cyc(1, 4'd0);
                                                            cyc(1, 4'd0);
                                                            cyc(1, 4'd5);
        idle_bus();                                         cyc(1, 4'd0);
        check("m1_sticky", 32'(es[1]), 32'h020);
        check("m1_rd_beats", 32'(rb[1]), 32'd2);

        // Mode 2: two reads answered on time, then one return slipped by a cycle.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) cyc(2, 4'd0);
        read = 1'b1;                                        cyc(2, 4'd0);
                                                            cyc(2, 4'd0);
        check("m2_outstanding_2", 32'(os[2]), 32'd2);
        idle_bus(); readdatavalid = 1'b1;                   cyc(2, 4'd0);
                                                            cyc(2, 4'd0);
        idle_bus();                                         cyc(2, 4'd0);
        check("m2_outstanding_0", 32'(os[2]), 32'd0);
        read = 1'b1;                                        cyc(2, 4'd0);
                                                            cyc(2, 4'd0);
        idle_bus(); readdatavalid = 1'b1;                   cyc(2, 4'd0);
        readdatavalid = 1'b0;                               cyc(2, 4'd5);
        readdatavalid = 1'b1;                               cyc(2, 4'd5);
        idle_bus();                                         cyc(2, 4'd0);
        check("m2_sticky", 32'(es[2]), 32'h020);
        check("m2_rd_beats", 32'(rb[2]), 32'd4);

        // Mode 3: fill to MAXPEND, overflow, drain, spurious return, then timeout.
        do_reset(1'b0);
        read = 1'b1;
        for (int i = 0; i < 8; i++) cyc(3, 4'd0);
        check("m3_outstanding_full", 32'(os[3]), 32'd8);
                                                            cyc(3, 4'd4);
        check("m3_outstanding_sat", 32'(os[3]), 32'd8);
        idle_bus(); readdatavalid = 1'b1;
        for (int i = 0; i < 8; i++) cyc(3, 4'd0);
        check("m3_outstanding_drained", 32'(os[3]), 32'd0);
                                                            cyc(3, 4'd3);
        idle_bus();                                         cyc(3, 4'd0);
        check("m3_rd_beats", 32'(rb[3]), 32'd8);
        read = 1'b1;                                        cyc(3, 4'd0);
        idle_bus();
        for (int i = 0; i < 255; i++) cyc(3, 4'd0);
                                                            cyc(3, 4'd8);
                                                            cyc(3, 4'd0);
        check("m3_sticky", 32'(es[3]), 32'h118);
        check("m3_outstanding_pending", 32'(os[3]), 32'd1);

        // Mode 4: burst stability, zero burstcount, missing begin pulse, burst reads.
        do_reset(1'b0);
        write = 1'b1; address = 8'h20; burstcount = 8'd4; beginbursttransfer = 1'b1;
                                                            cyc(4, 4'd0);
        beginbursttransfer = 1'b0; burstcount = 8'd3;       cyc(4, 4'd2);
        burstcount = 8'd4;                                  cyc(4, 4'd0);
                                                            cyc(4, 4'd0);
        idle_bus();                                         cyc(4, 4'd0);
        read = 1'b1; burstcount = 8'd0; beginbursttransfer = 1'b1;
                                                            cyc(4, 4'd6);
        idle_bus();                                         cyc(4, 4'd0);
        read = 1'b1; burstcount = 8'd2; beginbursttransfer = 1'b1;
                                                            cyc(4, 4'd0);
        check("m4_outstanding_2", 32'(os[4]), 32'd2);
        idle_bus(); readdatavalid = 1'b1;                   cyc(4, 4'd0);
                                                            cyc(4, 4'd0);
        idle_bus(); read = 1'b1;                            cyc(4, 4'd7);
        idle_bus(); readdatavalid = 1'b1;                   cyc(4, 4'd0);
        idle_bus();                                         cyc(4, 4'd0);
        check("m4_sticky", 32'(es[4]), 32'h0C4);
        check("m4_rd_beats", 32'(rb[4]), 32'd3);
        check("m4_outstanding_0", 32'(os[4]), 32'd0);

        // Reset in the middle of a write burst clears everything without an error.
        write = 1'b1; address = 8'h30; burstcount = 8'd4; beginbursttransfer = 1'b1;
                                                            cyc(4, 4'd0);
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) cyc(4, 4'd0);
        check("m4_sticky_after_rst", 32'(es[4]), 32'h000);
        check("m3_outstanding_after_rst", 32'(os[3]), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
